// File: rtl/xbram_pkg.sv
// Shared definitions for the BRAM port arbiter: FSM encoding and the log2 helper.
package xbram_pkg;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        StInit = ST_INIT,
        StRun  = ST_RUN
    } arb_state_e;

    // Ceiling log2, same rounding as the BRAM wrapper uses for its depth.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/xbram_rr_grant.sv
// Combinational round-robin grant: first requester strictly after ptr, wrapping.
module xbram_rr_grant #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan offsets 1..NUM_REQ from the pointer; the first hit wins.
    always_comb begin
        int unsigned cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[IDX_W'(cand)]) begin
                any                = 1'b1;
                gnt[IDX_W'(cand)]  = 1'b1;
                idx                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/xbram_port_arbiter.sv
// Round-robin sharing of one BRAM port between NUM_REQ requesters, with
// post-reset zero-fill and tagged read-response return.
module xbram_port_arbiter
    import xbram_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned INIT_EN      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           init_busy,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_din,
    input  logic [DATA_WIDTH-1:0]          ram_dout
);

    localparam int unsigned IDX_W  = log2(NUM_REQ);
    localparam int unsigned PIPE_D = 1 + READ_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    arb_state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]             init_cnt_q;
    logic [IDX_W-1:0]                  ptr_q;
    logic                              ram_we_q;
    logic [ADDR_WIDTH-1:0]             ram_addr_q;
    logic [DATA_WIDTH-1:0]             ram_din_q;
    logic [PIPE_D-1:0]                 pipe_vld_q;
    logic [PIPE_D-1:0][NUM_REQ-1:0]    pipe_tag_q;

    logic [NUM_REQ-1:0]                gnt;
    logic [IDX_W-1:0]                  gnt_idx;
    logic                              gnt_any;
    logic [NUM_REQ-1:0]                xfer;
    logic                              xfer_any;
    logic                              xfer_rd;
    logic                              init_last;
    logic                              sel_we;
    logic [ADDR_WIDTH-1:0]             sel_addr;
    logic [DATA_WIDTH-1:0]             sel_din;

    xbram_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // The last fill write is on the RAM port this cycle.
    assign init_last = ram_we_q && (ram_addr_q == LAST_ADDR);

    // Grants only in RUN and never while reset is held.
    assign xfer      = (state_q == StRun && !rst && gnt_any) ? gnt : '0;
    assign xfer_any  = |xfer;
    assign xfer_rd   = xfer_any && !sel_we;
    assign req_ready = xfer;
    assign init_busy = (state_q == StInit);

    // Mux the granted requester's payload.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_we   = req_we[i];
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state: leave INIT the cycle after the last fill write is issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (init_last) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_EN != 0) ? StInit : StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin pointer follows the last granted index.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (xfer_any) begin
            ptr_q <= gnt_idx;
        end
    end

    // Issue registers: fill sweep in INIT, granted request in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            init_cnt_q <= '0;
        end else if (state_q == StInit) begin
            if (init_last) begin
                ram_we_q <= 1'b0;
            end else begin
                ram_we_q   <= 1'b1;
                ram_addr_q <= init_cnt_q;
                ram_din_q  <= '0;
                init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
            end
        end else if (xfer_any) begin
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
        end else begin
            ram_we_q <= 1'b0;
        end
    end

    // Read tracking: stage k is visible k+1 cycles after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_vld_q[0] <= xfer_rd;
            pipe_tag_q[0] <= xfer_rd ? xfer : '0;
            for (int unsigned k = 1; k < PIPE_D; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

    // Last stage lines up with ram_dout; suppressed under reset so in-flight reads drop.
    assign rsp_valid = (!rst && state_q == StRun && pipe_vld_q[PIPE_D-1]) ?
                       pipe_tag_q[PIPE_D-1] : '0;
    assign rsp_rdata = (|rsp_valid) ? ram_dout : '0;

endmodule

// File: tb/tb_xbram_port_arbiter.sv
// Self-checking bench for xbram_port_arbiter with a behavioural RAM and reference model.
`timescale 1ns/1ps
module tb_xbram_port_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, ram_din, ram_dout;
    logic              init_busy, ram_we;
    logic [AW-1:0]     ram_addr;

    logic              rst2;
    logic [N-1:0]      req_valid2, req_ready2, req_we2, rsp_valid2;
    logic [N*AW-1:0]   req_addr2;
    logic [N*DW-1:0]   req_wdata2;
    logic [DW-1:0]     rsp_rdata2, ram_din2;
    logic              init_busy2, ram_we2;
    logic [AW-1:0]     ram_addr2;

    xbram_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .INIT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .init_busy(init_busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    xbram_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .INIT_EN(0)
    ) dut_noinit (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .init_busy(init_busy2),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_dout('0)
    );

    // Behavioural RAM port with RL-cycle registered read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RL-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    typedef struct {
        int           due;
        logic [N-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_last;
    exp_t          exp_q [$];

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        ref_last = N - 1;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Picks this cycle's winner by the round-robin rule and records its effect.
    task automatic model_step(output int win);
        int   a;
        exp_t e;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (ref_last + k) % N;
            if (win < 0 && req_valid[j]) win = j;
        end
        if (win >= 0) begin
            ref_last = win;
            a = int'(req_addr[win*AW +: AW]);
            if (req_we[win]) begin
                ref_mem[a] = req_wdata[win*DW +: DW];
            end else begin
                e.due  = cyc + 1 + RL;
                e.tag  = onehot(win);
                e.data = ref_mem[a];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pop_exp(output logic [N-1:0] v, output logic [DW-1:0] d);
        v = '0;
        d = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            v = exp_q[0].tag;
            d = exp_q[0].data;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        tick();
        tick();
        total++;
        if ({req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, init_busy} !==
            {4'b0, 4'b0, 32'b0, 1'b0, 6'b0, 32'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b rv=%b rd=%h we=%b a=%h din=%h busy=%b",
                     req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, init_busy);
        end
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= DEPTH + 1; c++) begin
            tick();
            total++;
            if (c <= DEPTH) begin
                if ({ram_we, ram_addr, ram_din, init_busy, req_ready, rsp_valid} !==
                    {1'b1, AW'(c - 1), DW'(0), 1'b1, N'(0), N'(0)}) begin
                    bad++;
                    $display("FAIL init_sweep c=%0d got we=%b a=%0d din=%h busy=%b rdy=%b rv=%b want a=%0d",
                             c, ram_we, ram_addr, ram_din, init_busy, req_ready, rsp_valid, c - 1);
                end
                if (c == DEPTH) req_valid = '0;
            end else begin
                if (init_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL init_done got busy=%b want 0", init_busy);
                end
            end
        end
    endtask

    task automatic test_zero_fill();
        int addrs [4] = '{0, 17, 63, 42};
        int w;
        logic [N-1:0] ev;
        logic [DW-1:0] ed;
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            if (k < 4) begin
                req_valid[3] = 1'b1;
                req_addr[3*AW +: AW] = AW'(addrs[k]);
            end
            #1;
            model_step(w);
            total++;
            if (req_ready !== onehot(w)) begin
                bad++;
                $display("FAIL zero_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(w));
            end
            tick();
            pop_exp(ev, ed);
            total++;
            if (rsp_valid !== ev || (ev != '0 && rsp_rdata !== ed)) begin
                bad++;
                $display("FAIL zero_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_rdata, ev, ed);
            end
        end
    endtask

    task automatic test_round_robin();
        int w;
        logic [N-1:0] ev;
        logic [DW-1:0] ed;
        for (int k = 0; k < 16; k++) begin
            clear_inputs();
            if (k < 12) begin
                req_valid = '1;
                for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i * 3);
            end
            #1;
            model_step(w);
            total++;
            if (req_ready !== onehot(w) || (k < 12 && req_ready !== onehot(k % N))) begin
                bad++;
                $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(k % N));
            end
            tick();
            pop_exp(ev, ed);
            total++;
            if (rsp_valid !== ev || (ev != '0 && rsp_rdata !== ed)) begin
                bad++;
                $display("FAIL rr_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_rdata, ev, ed);
            end
        end
    endtask

    task automatic test_write_read();
        int w;
        int t_rd = -100;
        logic [N-1:0] ev;
        logic [DW-1:0] ed;
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            if (k == 0) begin
                req_valid[2] = 1'b1;
                req_we[2]    = 1'b1;
                req_addr[2*AW +: AW]  = AW'(5);
                req_wdata[2*DW +: DW] = 32'hDEADBEEF;
            end else if (k == 1) begin
                req_valid[1] = 1'b1;
                req_addr[1*AW +: AW] = AW'(5);
                t_rd = cyc;
            end
            #1;
            model_step(w);
            total++;
            if (req_ready !== onehot(w)) begin
                bad++;
                $display("FAIL wr_rd_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(w));
            end
            tick();
            pop_exp(ev, ed);
            total++;
            if (rsp_valid !== ev || (ev != '0 && rsp_rdata !== ed)) begin
                bad++;
                $display("FAIL wr_rd_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_rdata, ev, ed);
            end
            if (cyc == t_rd + 3) begin
                total++;
                if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL wr_rd_data got=%b/%h want=0010/deadbeef", rsp_valid, rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int nresp = 0;
        int first = 0;
        logic [N-1:0] ev;
        logic [DW-1:0] ed;
        for (int k = 0; k < 20; k++) begin
            clear_inputs();
            if (k < 16) begin
                req_valid[0] = 1'b1;
                req_we[0]    = (k < 8);
                req_addr[0 +: AW]  = AW'(k % 8);
                req_wdata[0 +: DW] = 32'h100 + DW'(k % 8);
            end
            #1;
            model_step(w);
            total++;
            if (req_ready !== onehot(w)) begin
                bad++;
                $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(w));
            end
            tick();
            pop_exp(ev, ed);
            total++;
            if (rsp_valid !== ev || (ev != '0 && rsp_rdata !== ed)) begin
                bad++;
                $display("FAIL b2b_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_rdata, ev, ed);
            end
            if (rsp_valid === 4'b0001) begin
                if (nresp == 0) first = cyc;
                total++;
                if (rsp_rdata !== 32'h100 + DW'(nresp) || cyc != first + nresp) begin
                    bad++;
                    $display("FAIL b2b_order n=%0d got=%h want=%h", nresp, rsp_rdata, 32'h100 + nresp);
                end
                nresp++;
            end
        end
        total++;
        if (nresp != 8) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=8", nresp);
        end
    endtask

    task automatic test_random();
        int w = -1;
        logic [N-1:0] ev;
        logic [DW-1:0] ed;
        clear_inputs();
        for (int k = 0; k < 405; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || w == i) begin
                    if (k < 400 && $urandom_range(0, 1) == 1) begin
                        req_valid[i] = 1'b1;
                        req_we[i]    = ($urandom_range(0, 2) == 0);
                        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                        req_wdata[i*DW +: DW] = $urandom;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            #1;
            model_step(w);
            total++;
            if (req_ready !== onehot(w)) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(w));
            end
            tick();
            pop_exp(ev, ed);
            total++;
            if (rsp_valid !== ev || (ev != '0 && rsp_rdata !== ed)) begin
                bad++;
                $display("FAIL rand_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_rdata, ev, ed);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        int w;
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            req_valid[k] = 1'b1;
            req_addr[k*AW +: AW] = AW'(k);
            #1;
            model_step(w);
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        total++;
        if (rsp_valid !== '0) begin
            bad++;
            $display("FAIL midrst_hold got=%b want=0000", rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== '0 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL midrst_drop got rv=%b we=%b want 0000/0", rsp_valid, ram_we);
        end
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= DEPTH + 1; c++) begin
            tick();
            total++;
            if (c <= DEPTH) begin
                if ({ram_we, ram_addr, ram_din, init_busy, rsp_valid} !==
                    {1'b1, AW'(c - 1), DW'(0), 1'b1, N'(0)}) begin
                    bad++;
                    $display("FAIL midrst_sweep c=%0d got we=%b a=%0d busy=%b rv=%b want a=%0d",
                             c, ram_we, ram_addr, init_busy, rsp_valid, c - 1);
                end
            end else if (init_busy !== 1'b0 || rsp_valid !== '0) begin
                bad++;
                $display("FAIL midrst_done got busy=%b rv=%b want 0/0000", init_busy, rsp_valid);
            end
        end
    endtask

    task automatic test_init_off();
        req_valid2 = 4'b0100;
        req_we2    = 4'b0100;
        req_addr2  = '0;
        req_addr2[2*AW +: AW] = AW'(9);
        req_wdata2 = '0;
        rst2 = 1'b1;
        tick();
        total++;
        if (req_ready2 !== '0 || init_busy2 !== 1'b0 || ram_we2 !== 1'b0) begin
            bad++;
            $display("FAIL noinit_reset got rdy=%b busy=%b we=%b want 0000/0/0",
                     req_ready2, init_busy2, ram_we2);
        end
        rst2 = 1'b0;
        #1;
        total++;
        if (req_ready2 !== 4'b0100 || init_busy2 !== 1'b0) begin
            bad++;
            $display("FAIL noinit_grant got rdy=%b busy=%b want 0100/0", req_ready2, init_busy2);
        end
        tick();
        req_valid2 = '0;
        total++;
        if (ram_we2 !== 1'b1 || ram_addr2 !== AW'(9) || rsp_valid2 !== '0) begin
            bad++;
            $display("FAIL noinit_issue got we=%b a=%0d rv=%b want 1/9/0000", ram_we2, ram_addr2, rsp_valid2);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        clear_inputs();
        rst        = 1'b1;
        rst2       = 1'b1;
        req_valid2 = '0;
        req_we2    = '0;
        req_addr2  = '0;
        req_wdata2 = '0;
        test_reset();
        test_zero_fill();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_init_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
